ternary_word_alu: RTL and testbench
===================================

Name: ternary_word_alu

Overview:
- Multi-trit ternary ALU with a valid/ready handshake on both input and output.
- Generalises the single-trit MIN/MAX/ANY/CONSENSUS gates to WIDTH-trit words and adds a multi-cycle serial ternary adder.
- Sits between a ternary operand source and a result consumer. Processes one transaction at a time.
- Trit encoding: 2 bits per trit, 00=0, 01=1, 10=2, 11=invalid. Trit i occupies bits [2i+1:2i]; trit 0 is least significant.

Parameters:
- WIDTH, 8, trits per operand/result word (>=1).
- STEP, 2, trits processed per cycle by ADD. WIDTH % STEP must be 0; otherwise elaboration fails.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  operation select.
- a  input  2*WIDTH  operand A.
- b  input  2*WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  2*WIDTH  result word.
- carry_out  output  1  ADD final carry (0/1); 0 for other ops.
- err  output  1  reserved opcode, or invalid trit (see Optional Feature).

Behaviour:
- Reset (async, rst_n low) clears the following, regardless of state or mid-operation:
  - state=IDLE, out_valid=0, result=0, carry_out=0, err=0, and all internal operand/carry registers.
  - in_ready is decoded from state, so it reads 1 once reset is applied.
- Acceptance: in_valid & in_ready at a rising edge. a, b and op are captured; later input changes are ignored.
- Per-trit ops, applied independently to each trit pair (x, y), result in 1 edge:
  - 000 MIN: min(x,y).
  - 001 MAX: max(x,y).
  - 010 ANY: clamp(x+y-1, 0, 2).
  - 011 CONS: x if x==y, else 1.
  - 101 NEG: 2-x (b ignored).
- 100 ADD: unsigned base-3 addition of a+b.
  - STEP trits per cycle, starting at the LSB, with the carry (0/1) registered between chunks.
  - Final carry goes to carry_out.
- 110, 111: reserved. result=0, carry_out=0, err=1, latency 1 edge.
- FSM:
  - IDLE: accept -> DONE for per-trit/reserved ops, ADD_RUN for ADD (chunk counter=0, carry=0).
  - ADD_RUN: each edge computes chunk k and increments the counter. The edge computing the last chunk (k = WIDTH/STEP-1) goes to DONE.
  - DONE: out_valid=1. Goes to IDLE on out_ready; stays otherwise.
- Latency from acceptance edge to out_valid high:
  - Per-trit and reserved ops: 1 edge.
  - ADD: WIDTH/STEP+1 edges (5 at default).
- Backpressure: while out_valid & !out_ready, result, carry_out and err are held stable and in_ready=0.
- No overlap: a new operand is accepted no earlier than the edge after the result handshake, so sustained throughput is at most one op per 2 cycles.
- Output registers: result, carry_out and err are registered and update only on the edge entering DONE. ADD writes partial sums into an internal register, not into result.
- Wrap-around: ADD overflow drops the carry out of the MSB into carry_out; result holds the low WIDTH trits.

Optional Feature:
- Macro TERNARY_INVCHK_EN.
- Defined: any 11 trit code in a used operand (b is unused for NEG) sets err=1 and result=0, carry_out=0. Latency is 1 edge even for ADD (straight to DONE).
- Undefined: no trit check. Code 11 is decoded as 2 before every operation, and err reports reserved opcodes only.

Test Plan:
1. WIDTH=8, STEP=2. MIN with a=16'hAAAA, b=16'h5555 -> result=16'h5555, err=0, out_valid one edge after acceptance. MAX on the same operands -> 16'hAAAA.
2. ANY with a=16'h0000, b=16'hAAAA -> 16'h5555. CONS on the same operands -> 16'h5555. CONS with a=b=16'hAAAA -> 16'hAAAA. NEG with a=16'h0000 -> 16'hAAAA.
3. ADD with a=16'hAAAA (6560), b=16'h0001 -> result=16'h0000, carry_out=1, out_valid exactly 5 edges after acceptance. ADD with a=16'h0001, b=16'h0001 -> 16'h0002, carry_out=0.
4. Backpressure: complete an ADD, hold out_ready=0 for 10 cycles -> result, carry_out and out_valid are stable and in_ready=0 throughout. Raise out_ready -> next cycle in_ready=1, out_valid=0.
5. Reset mid-ADD: assert rst_n=0 in the 2nd ADD_RUN cycle -> out_valid=0, result=0, carry_out=0 and in_ready=1 immediately (asynchronously). A following MIN completes correctly.
6. op=3'b111 -> err=1, result=0. With TERNARY_INVCHK_EN: ADD with a=16'h0003 -> err=1 after 1 edge. Without the macro, the same ADD with b=0 -> result=16'h0002, err=0.

Source files
------------

// File: rtl/ternary_word_alu.sv
// ---------------------------------------------------------------------------
// ternary_word_alu
//   Ternary ALU for WIDTH-trit words. Trits are 2-bit codes (00=0, 01=1,
//   10=2, 11=invalid); trit i sits at bits [2i+1:2i], trit 0 is the LSB.
//   Per-trit ops (MIN/MAX/ANY/CONS/NEG) finish in one edge. ADD is a serial
//   base-3 adder that handles STEP trits per cycle, LSB chunk first.
//   Only one transaction is in flight at a time.
//
//   Optional build macro: TERNARY_INVCHK_EN
//     defined   - any 11 trit in a used operand gives err=1, result=0
//     undefined - code 11 is read as 2 and err flags reserved opcodes only
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   op[2:0]              000 MIN, 001 MAX, 010 ANY, 011 CONS, 100 ADD,
//                        101 NEG, 11x reserved
//   a, b [2*WIDTH-1:0]   operands (b is ignored by NEG)
//   out_valid/out_ready  result handshake
//   result               result word
//   carry_out            final ADD carry, 0 for other ops
//   err                  reserved opcode or invalid trit
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ternary_word_alu #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               err
);

  if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_cfg
    $error("ternary_word_alu: WIDTH must be a positive multiple of STEP");
  end

  localparam int NCH = WIDTH / STEP;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [2:0] OP_MIN  = 3'b000;
  localparam logic [2:0] OP_MAX  = 3'b001;
  localparam logic [2:0] OP_ANY  = 3'b010;
  localparam logic [2:0] OP_CONS = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_NEG  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ADD_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, res_q, res_d;
  logic                 carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rsv, inv;
  logic [2*STEP:0]      chunk;
  logic [2*WIDTH-1:0]   sum_nx;

  function automatic logic [1:0] fix_trit(input logic [1:0] t);
    return (t == 2'b11) ? 2'b10 : t;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_word(input logic [2*WIDTH-1:0] w);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[2*i+:2] = fix_trit(w[2*i+:2]);
    return r;
  endfunction

`ifdef TERNARY_INVCHK_EN
  function automatic logic has_inv(input logic [2*WIDTH-1:0] w);
    logic f;
    f = 1'b0;
    for (int i = 0; i < WIDTH; i++) f = f | (w[2*i+:2] == 2'b11);
    return f;
  endfunction
`endif

  // Inputs are already decoded to 0..2, so plain unsigned compares work.
  function automatic logic [1:0] trit_op(input logic [2:0] o, input logic [1:0] x,
                                         input logic [1:0] y);
    logic [2:0] s;
    logic [1:0] r;
    s = {1'b0, x} + {1'b0, y};
    r = 2'd0;
    case (o)
      OP_MIN:  r = (x < y) ? x : y;
      OP_MAX:  r = (x > y) ? x : y;
      // clamp(x+y-1, 0, 2)
      OP_ANY:  r = (s <= 3'd1) ? 2'd0 : ((s >= 3'd3) ? 2'd2 : 2'd1);
      OP_CONS: r = (x == y) ? x : 2'd1;
      OP_NEG:  r = 2'd2 - x;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] word_op(input logic [2:0] o,
                                                 input logic [2*WIDTH-1:0] x,
                                                 input logic [2*WIDTH-1:0] y);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[2*i+:2] = trit_op(o, x[2*i+:2], y[2*i+:2]);
    return r;
  endfunction

  // Ripple base-3 add of one STEP-trit chunk; returns {carry, digits}.
  function automatic logic [2*STEP:0] add_chunk(input logic [2*STEP-1:0] x,
                                                input logic [2*STEP-1:0] y,
                                                input logic cin);
    logic             c;
    logic [2:0]       s;
    logic [2*STEP-1:0] d;
    c = cin;
    d = '0;
    for (int i = 0; i < STEP; i++) begin
      s = {1'b0, x[2*i+:2]} + {1'b0, y[2*i+:2]} + {2'b00, c};
      if (s >= 3'd3) begin
        d[2*i+:2] = 2'(s - 3'd3);
        c = 1'b1;
      end else begin
        d[2*i+:2] = s[1:0];
        c = 1'b0;
      end
    end
    return {c, d};
  endfunction

  assign rsv = (op[2:1] == 2'b11);

  always_comb begin
`ifdef TERNARY_INVCHK_EN
    inv = !rsv && (has_inv(a) || ((op != OP_NEG) && has_inv(b)));
`else
    inv = 1'b0;
`endif
  end

  // Operands shift right one chunk per cycle so the adder always reads the
  // low chunk; finished digits enter sum_q from the top, so after NCH
  // chunks sum_q holds the whole word in place.
  assign chunk = add_chunk(a_q[2*STEP-1:0], b_q[2*STEP-1:0], carry_q);

  if (STEP == WIDTH) begin : g_sum_full
    assign sum_nx = chunk[2*STEP-1:0];
  end else begin : g_sum_part
    assign sum_nx = {chunk[2*STEP-1:0], sum_q[2*WIDTH-1:2*STEP]};
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = ((op == OP_ADD) && !inv) ? S_ADD_RUN : S_DONE;
      S_ADD_RUN: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // ---- datapath next state ----
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((op == OP_ADD) && !inv) begin
            a_d     = fix_word(a);
            b_d     = fix_word(b);
            carry_d = 1'b0;
            cnt_d   = '0;
          end else begin
            res_d  = (rsv || inv) ? '0 : word_op(op, fix_word(a), fix_word(b));
            cout_d = 1'b0;
            err_d  = rsv || inv;
          end
        end
      end
      S_ADD_RUN: begin
        a_d     = a_q >> (2*STEP);
        b_d     = b_q >> (2*STEP);
        sum_d   = sum_nx;
        carry_d = chunk[2*STEP];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d  = sum_nx;
          cout_d = chunk[2*STEP];
          err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ternary_word_alu.sv
`timescale 1ns/1ps
module tb_ternary_word_alu;
  localparam int W = 8;
  localparam int S = 2;
  localparam int NB = 2*W;
  localparam int ADD_LAT = W/S + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic          in_ready, out_valid, carry_out, err;
  logic [NB-1:0] result;

  int n_checks = 0;
  int n_err = 0;

  ternary_word_alu #(.WIDTH(W), .STEP(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int dec(input logic [1:0] t);
    return (t == 2'b11) ? 2 : int'(t);
  endfunction

  function automatic int val(input logic [NB-1:0] w);
    int v = 0;
    for (int i = W-1; i >= 0; i--) v = v*3 + dec(w[2*i+:2]);
    return v;
  endfunction

  function automatic logic [NB-1:0] to_word(input int v);
    logic [NB-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      w[2*i+:2] = 2'(v % 3);
      v = v / 3;
    end
    return w;
  endfunction

  function automatic bit has11(input logic [NB-1:0] w);
    for (int i = 0; i < W; i++) if (w[2*i+:2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int trit_model(input int o, input int x, input int y);
    int s;
    case (o)
      0: return (x < y) ? x : y;
      1: return (x > y) ? x : y;
      2: begin
        s = x + y - 1;
        return (s < 0) ? 0 : ((s > 2) ? 2 : s);
      end
      3: return (x == y) ? x : 1;
      5: return 2 - x;
      default: return 0;
    endcase
  endfunction

  task automatic model(input logic [2:0] o, input logic [NB-1:0] x, input logic [NB-1:0] y,
                       output logic [NB-1:0] r, output logic co, output logic er,
                       output int lat);
    int pow = 1;
    int s;
    bit rsv, inv;
    for (int i = 0; i < W; i++) pow = pow * 3;
    rsv = (o == 3'd6) || (o == 3'd7);
    inv = 1'b0;
`ifdef TERNARY_INVCHK_EN
    inv = !rsv && (has11(x) || ((o != 3'd5) && has11(y)));
`endif
    r = '0; co = 1'b0; er = 1'b0; lat = 1;
    if (rsv || inv) begin
      er = 1'b1;
    end else if (o == 3'd4) begin
      s = val(x) + val(y);
      r = to_word(s % pow);
      co = (s >= pow);
      lat = ADD_LAT;
    end else begin
      for (int i = 0; i < W; i++)
        r[2*i+:2] = 2'(trit_model(int'(o), dec(x[2*i+:2]), dec(y[2*i+:2])));
    end
  endtask

  function automatic logic [NB-1:0] rand_word(input bit allow_inv);
    logic [NB-1:0] w = '0;
    int r;
    for (int i = 0; i < W; i++) begin
      r = $urandom_range(0, 15);
      w[2*i+:2] = (allow_inv && r == 0) ? 2'b11 : 2'(r % 3);
    end
    return w;
  endfunction

  // Drives one transaction from IDLE and collects the response.
  task automatic run_op(input logic [2:0] o, input logic [NB-1:0] x, input logic [NB-1:0] y,
                        output int lat, output logic [NB-1:0] r, output logic co,
                        output logic er);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = NB'($urandom); b = NB'($urandom); op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; co = carry_out; er = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_checks++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  typedef struct {
    logic [2:0]    o;
    logic [NB-1:0] x, y, er;
    logic          co, e;
    int            lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    int lat;
    logic [NB-1:0] r;
    logic co, er;
    v[0] = '{3'd0, 16'hAAAA, 16'h5555, 16'h5555, 1'b0, 1'b0, 1};
    v[1] = '{3'd1, 16'hAAAA, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1};
    v[2] = '{3'd2, 16'h0000, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1};
    v[3] = '{3'd3, 16'h0000, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1};
    v[4] = '{3'd3, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 1};
    v[5] = '{3'd5, 16'h0000, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1};
    v[6] = '{3'd4, 16'hAAAA, 16'h0001, 16'h0000, 1'b1, 1'b0, 5};
    v[7] = '{3'd4, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 5};
    v[8] = '{3'd7, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 1};
    v[9] = '{3'd6, 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].o, v[i].x, v[i].y, lat, r, co, er);
      n_checks++; if (r !== v[i].er) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, v[i].er); end
      n_checks++; if (co !== v[i].co) begin n_err++; $display("FAIL dir%0d_carry got=%b exp=%b", i, co, v[i].co); end
      n_checks++; if (er !== v[i].e) begin n_err++; $display("FAIL dir%0d_err got=%b exp=%b", i, er, v[i].e); end
      n_checks++; if (lat !== v[i].lat) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_invchk();
    int lat;
    logic [NB-1:0] r;
    logic co, er;
    run_op(3'd4, 16'h0003, 16'h0000, lat, r, co, er);
`ifdef TERNARY_INVCHK_EN
    n_checks++; if ({er, r, co} !== {1'b1, 16'h0000, 1'b0}) begin n_err++; $display("FAIL invchk_add err=%b result=%h carry=%b exp err=1 result=0000 carry=0", er, r, co); end
    n_checks++; if (lat !== 1) begin n_err++; $display("FAIL invchk_latency got=%0d exp=1", lat); end
`else
    n_checks++; if ({er, r, co} !== {1'b0, 16'h0002, 1'b0}) begin n_err++; $display("FAIL invchk_add err=%b result=%h carry=%b exp err=0 result=0002 carry=0", er, r, co); end
    n_checks++; if (lat !== ADD_LAT) begin n_err++; $display("FAIL invchk_latency got=%0d exp=%0d", lat, ADD_LAT); end
`endif
  endtask

  task automatic test_random();
    int lat, elat;
    logic [NB-1:0] x, y, r, er_r;
    logic co, er, eco, eer;
    logic [2:0] o;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = rand_word(1'b1);
      y = rand_word(1'b1);
      model(o, x, y, er_r, eco, eer, elat);
      run_op(o, x, y, lat, r, co, er);
      n_checks++;
      if ({r, co, er} !== {er_r, eco, eer} || lat !== elat) begin
        n_err++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got r=%h c=%b e=%b lat=%0d exp r=%h c=%b e=%b lat=%0d",
                 i, o, x, y, r, co, er, lat, er_r, eco, eer, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] x, y, er_r, r0;
    logic eco, eer, co0;
    int elat, waited;
    x = rand_word(1'b0);
    y = rand_word(1'b0);
    model(3'd4, x, y, er_r, eco, eer, elat);
    op = 3'd4; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 1;
    while (!out_valid && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    r0 = result; co0 = carry_out;
    n_checks++; if ({r0, co0} !== {er_r, eco} || waited !== elat) begin n_err++; $display("FAIL bp_result got=%h/%b lat=%0d exp=%h/%b lat=%0d", r0, co0, waited, er_r, eco, elat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result, carry_out} !== {1'b1, 1'b0, r0, co0}) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h c=%b exp v=1 rdy=0 r=%h c=%b", i, out_valid, in_ready, result, carry_out, r0, co0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_add();
    int lat;
    logic [NB-1:0] r;
    logic co, er;
    run_op(3'd4, 16'hAAAA, 16'h0001, lat, r, co, er);
    op = 3'd4; a = 16'hAAAA; b = 16'hAAAA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (result !== '0) begin n_err++; $display("FAIL rst_mid_result got=%h exp=0", result); end
    n_checks++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_carry got=%b exp=0", carry_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(3'd0, 16'h5555, 16'hAAAA, lat, r, co, er);
    n_checks++; if ({r, co, er} !== {16'h5555, 1'b0, 1'b0} || lat !== 1) begin n_err++; $display("FAIL rst_mid_min got r=%h c=%b e=%b lat=%0d exp r=5555 c=0 e=0 lat=1", r, co, er, lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invchk();
    test_random();
    test_backpressure();
    test_reset_mid_add();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
